main_memory_icb_bridge: RTL and testbench

Parametrised bridge between the cache's wide line-sized memory port and a narrow ICB target, such as the QSPI flash XIP window or an SRAM controller. Each line read is split into BEATS = LINE_DW/BEAT_DW ICB beats and the returned data is assembled into one line. Line writes (write-back) are split the same way. Up to MAX_OUTST commands can be in flight, response errors are reported, and critical-word-first ordering is optional. It replaces the fixed 8x32-bit, one-beat-at-a-time read-only refill FSM.

---
 rtl/main_memory_icb_bridge.sv | 175 +++++++++++++++++
 tb/tb_main_memory_icb_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_icb_bridge.sv
// Cache line port to narrow ICB bridge: splits each line into beats with a
// bounded outstanding window. Macro MAIN_MEMORY_ICB_BRIDGE_CWF_EN: wrap-order reads.
module main_memory_icb_bridge #(
  parameter int          ADDR_W    = 24,
  parameter int          LINE_DW   = 256,
  parameter int          BEAT_DW   = 32,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_cmd_valid,
  output logic                   mem_cmd_ready,
  input  logic                   mem_cmd_read,
  input  logic [ADDR_W-1:0]      mem_cmd_addr,
  input  logic [LINE_DW-1:0]     mem_cmd_wdata,
  input  logic [LINE_DW/8-1:0]   mem_cmd_wmask,
  output logic                   mem_rsp_valid,
  input  logic                   mem_rsp_ready,
  output logic [LINE_DW-1:0]     mem_rsp_rdata,
  output logic                   mem_rsp_err,
  output logic                   icb_cmd_valid,
  input  logic                   icb_cmd_ready,
  output logic [31:0]            icb_cmd_addr,
  output logic                   icb_cmd_read,
  output logic [BEAT_DW-1:0]     icb_cmd_wdata,
  output logic [BEAT_DW/8-1:0]   icb_cmd_wmask,
  input  logic                   icb_rsp_valid,
  output logic                   icb_rsp_ready,
  input  logic [BEAT_DW-1:0]     icb_rsp_rdata,
  input  logic                   icb_rsp_err,
  output logic                   busy
);

  localparam int BEATS = LINE_DW / BEAT_DW;
  localparam int BI_W  = $clog2(BEATS);
  localparam int BB    = BEAT_DW / 8;
  localparam int MW    = BEAT_DW / 8;
  localparam int OFF   = $clog2(BB);
  localparam int LSB   = OFF + BI_W;
  localparam int CW    = BI_W + 1;

  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);
  localparam logic [2:0]    MAXO_C  = 3'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 rd_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_DW-1:0]   wdata_q;
  logic [LINE_DW/8-1:0] wmask_q;
  logic [CW-1:0]        iss_cnt;
  logic [CW-1:0]        rsp_cnt;
  logic [2:0]           outst;
  logic [LINE_DW-1:0]   rdata_q;
  logic                 err_q;

  logic                 cmd_hs;
  logic                 rsp_hs;
  logic [BI_W-1:0]      idx;
  logic [BI_W-1:0]      ridx;
  logic [ADDR_W-1:0]    line_base;
  logic                 unused_lo;

  assign cmd_hs    = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hs    = icb_rsp_valid & icb_rsp_ready;
  assign line_base = {addr_q[ADDR_W-1:LSB], {LSB{1'b0}}};
  assign unused_lo = ^addr_q[LSB-1:0];

`ifdef MAIN_MEMORY_ICB_BRIDGE_CWF_EN
  logic [BI_W-1:0] start;
  assign start = addr_q[LSB-1:OFF];
  assign idx   = rd_q ? start + iss_cnt[BI_W-1:0]
                      : iss_cnt[BI_W-1:0];
  assign ridx  = rd_q ? start + rsp_cnt[BI_W-1:0]
                      : rsp_cnt[BI_W-1:0];
`else
  assign idx  = iss_cnt[BI_W-1:0];
  assign ridx = rsp_cnt[BI_W-1:0];
`endif

  // Beat command fields are taken from the latched line at slice idx
  assign icb_cmd_addr  = BASE_ADDR + 32'(line_base)
                       + 32'(idx) * 32'(BB);
  assign icb_cmd_read  = rd_q;
  assign icb_cmd_wdata = wdata_q[idx*BEAT_DW +: BEAT_DW];
  assign icb_cmd_wmask = rd_q ? {MW{1'b1}}
                              : wmask_q[idx*MW +: MW];
  assign mem_rsp_rdata = rdata_q;
  assign mem_rsp_err   = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mem_cmd_valid) state_d = XFER;
      XFER: if (rsp_hs && rsp_cnt == LAST_C) state_d = RESP;
      RESP: if (mem_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    mem_cmd_ready = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      IDLE: begin
        mem_cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      XFER: begin
        icb_cmd_valid = (iss_cnt < BEATS_C) && (outst < MAXO_C);
        icb_rsp_ready = 1'b1;
      end
      RESP: mem_rsp_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Request latch, beat counters, outstanding window and line assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      iss_cnt <= '0;
      rsp_cnt <= '0;
      outst   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (mem_cmd_valid) begin
        rd_q    <= mem_cmd_read;
        addr_q  <= mem_cmd_addr;
        wdata_q <= mem_cmd_wdata;
        wmask_q <= mem_cmd_wmask;
        iss_cnt <= '0;
        rsp_cnt <= '0;
        outst   <= '0;
        err_q   <= 1'b0;
      end
    end else if (state_q == XFER) begin
      if (cmd_hs) iss_cnt <= iss_cnt + CW'(1);
      if (rsp_hs) begin
        rsp_cnt <= rsp_cnt + CW'(1);
        err_q   <= err_q | icb_rsp_err;
        if (rd_q) rdata_q[ridx*BEAT_DW +: BEAT_DW] <= icb_rsp_rdata;
      end
      unique case ({cmd_hs, rsp_hs})
        2'b10:   outst <= outst + 3'd1;
        2'b01:   outst <= outst - 3'd1;
        default: outst <= outst;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_icb_bridge.sv
// Scoreboard bench for main_memory_icb_bridge: queued beat/line expectations,
// a modelled ICB target with configurable stall, latency and error beat.
module tb_main_memory_icb_bridge;

  localparam int BEATS = 8;
  localparam int MAXO  = 2;
`ifdef MAIN_MEMORY_ICB_BRIDGE_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_cmd_valid, mem_cmd_ready, mem_cmd_read;
  logic [23:0]  mem_cmd_addr;
  logic [255:0] mem_cmd_wdata;
  logic [31:0]  mem_cmd_wmask;
  logic         mem_rsp_valid, mem_rsp_ready;
  logic [255:0] mem_rsp_rdata;
  logic         mem_rsp_err;
  logic         icb_cmd_valid, icb_cmd_ready;
  logic [31:0]  icb_cmd_addr;
  logic         icb_cmd_read;
  logic [31:0]  icb_cmd_wdata;
  logic [3:0]   icb_cmd_wmask;
  logic         icb_rsp_valid, icb_rsp_ready;
  logic [31:0]  icb_rsp_rdata;
  logic         icb_rsp_err;
  logic         busy;

  main_memory_icb_bridge #(
    .ADDR_W(24), .LINE_DW(256), .BEAT_DW(32),
    .BASE_ADDR(32'h2000_0000), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_read(mem_cmd_read), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wmask(mem_cmd_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bcmd_t;

  typedef struct packed {
    logic [255:0] rdata;
    logic         err;
  } lrsp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } tresp_t;

  bcmd_t  exp_cmd_q[$];
  lrsp_t  exp_rsp_q[$];
  tresp_t tq[$];

  int checks = 0;
  int passed = 0;

  int lat = 1, stall = 0, err_idx = -1;
  logic [7:0] tag = 8'h00;
  int cyc = 0, wait_cnt = 0, ncmd = 0;
  int outst_tb = 0, outst_max = 0;
  logic [255:0] last_line = '0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] beat_data(input int b);
    return {8'hA0, tag, 12'h000, 4'(b)};
  endfunction

  // ICB target: samples handshakes at negedge, drives after posedge
  initial begin : target
    bit c_hs, r_hs, rst_seen;
    logic [31:0] c_addr;
    int bi;
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0;
    icb_rsp_rdata = '0;
    icb_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      c_hs     = icb_cmd_valid && icb_cmd_ready && rst_n;
      r_hs     = icb_rsp_valid && icb_rsp_ready && rst_n;
      rst_seen = !rst_n;
      c_addr   = icb_cmd_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_seen) begin
        tq.delete();
        outst_tb = 0;
      end else begin
        if (r_hs) begin
          void'(tq.pop_front());
          outst_tb--;
        end
        if (c_hs) begin
          bi = int'((c_addr >> 2) & 32'h7);
          tq.push_back('{due: cyc + lat - 1, data: beat_data(bi),
                         err: (bi == err_idx)});
          outst_tb++;
          ncmd++;
          if (outst_tb > outst_max) outst_max = outst_tb;
        end
      end
      wait_cnt      = c_hs ? 0 : wait_cnt + 1;
      icb_cmd_ready = (wait_cnt >= stall);
      if (tq.size() > 0 && tq[0].due <= cyc) begin
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = tq[0].data;
        icb_rsp_err   = tq[0].err;
      end else begin
        icb_rsp_valid = 1'b0;
        icb_rsp_rdata = '0;
        icb_rsp_err   = 1'b0;
      end
    end
  end

  // Monitor: compares beat commands and line responses against queues
  always @(negedge clk) begin : monitor
    bcmd_t e, got;
    if (rst_n) begin
      if (icb_cmd_valid && icb_cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          check("icb_cmd_extra", 256'(icb_cmd_addr), 256'(0));
        end else begin
          e   = exp_cmd_q.pop_front();
          got = '{icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask};
          check("icb_cmd", 256'(got), 256'(e));
        end
      end
      if (mem_rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          check("mem_rsp_extra", 256'(mem_rsp_valid), 256'(0));
        end else begin
          check("rsp_rdata", mem_rsp_rdata, exp_rsp_q[0].rdata);
          check("rsp_err", 256'(mem_rsp_err), 256'(exp_rsp_q[0].err));
          check("resp_cmd_ready", 256'(mem_cmd_ready), 256'(0));
          if (mem_rsp_ready) void'(exp_rsp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input bit rd, input logic [23:0] addr,
                       input logic [255:0] wd, input logic [31:0] wm);
    bcmd_t e;
    lrsp_t r;
    int start, idx, n;
    logic [31:0] lb;
    start = (CWF && rd) ? int'((addr >> 2) & 24'h7) : 0;
    lb    = {8'h00, addr & 24'hFFFFE0};
    for (int i = 0; i < BEATS; i++) begin
      idx     = (start + i) % BEATS;
      e.addr  = 32'h2000_0000 + lb + 32'(idx * 4);
      e.rd    = rd;
      e.wdata = wd[idx*32 +: 32];
      e.wmask = rd ? 4'hF : wm[idx*4 +: 4];
      exp_cmd_q.push_back(e);
    end
    if (rd) begin
      for (int b = 0; b < BEATS; b++) r.rdata[b*32 +: 32] = beat_data(b);
      last_line = r.rdata;
    end else begin
      r.rdata = last_line;
    end
    r.err = (err_idx >= 0 && err_idx < BEATS);
    exp_rsp_q.push_back(r);
    mem_cmd_read  = rd;
    mem_cmd_addr  = addr;
    mem_cmd_wdata = wd;
    mem_cmd_wmask = wm;
    mem_cmd_valid = 1'b1;
    n = 0;
    while (!mem_cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    mem_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_cmd_q.size() != 0) && n < max) begin
      @(posedge clk); n++;
    end
    if (n >= max) begin
      checks++;
      $display("FAIL done_timeout: got %0d cycles required < %0d", n, max);
      exp_rsp_q.delete();
      exp_cmd_q.delete();
    end
    #1;
  endtask

  task automatic check_idle(input string tagname);
    check({tagname, "_cmd_ready"}, 256'(mem_cmd_ready), 256'(1));
    check({tagname, "_icb_cmd_valid"}, 256'(icb_cmd_valid), 256'(0));
    check({tagname, "_icb_rsp_ready"}, 256'(icb_rsp_ready), 256'(0));
    check({tagname, "_rsp_valid"}, 256'(mem_rsp_valid), 256'(0));
    check({tagname, "_busy"}, 256'(busy), 256'(0));
    check({tagname, "_rdata"}, mem_rsp_rdata, 256'(0));
    check({tagname, "_err"}, 256'(mem_rsp_err), 256'(0));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [255:0] wd;
    int n, n0;
    rst_n         = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_read  = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    mem_cmd_wmask = '0;
    mem_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Incrementing read with 1-cycle target and latency measurement
    tag = 8'h00; lat = 1; stall = 0; err_idx = -1;
    issue(1'b1, 24'h000040, 256'h0, 32'h0);
    n = 1;
    while (!mem_rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("read_latency", 256'(n), 256'(BEATS + 2));
    wait_done(200);

    // Write-back with partial byte mask; read line must stay unchanged
    for (int i = 0; i < BEATS; i++) wd[i*32 +: 32] = 32'hD000_0000 + 32'(i * 32'h11);
    tag = 8'h77;
    issue(1'b0, 24'h000100, wd, 32'h0000_00FF);
    wait_done(200);

    // Stalling target: 3 idle cycles per beat, 4-cycle response latency
    tag = 8'h03; lat = 4; stall = 3; outst_max = 0; n0 = ncmd;
    issue(1'b1, 24'h000080, 256'h0, 32'h0);
    wait_done(500);
    check("stall_beats", 256'(ncmd - n0), 256'(BEATS));
    check("stall_outst_le_max", 256'(outst_max <= MAXO), 256'(1));

    // Ready target with long latency fills the outstanding window
    tag = 8'h0C; lat = 4; stall = 0; outst_max = 0;
    issue(1'b1, 24'h0000C0, 256'h0, 32'h0);
    wait_done(500);
    check("window_outst_max", 256'(outst_max), 256'(MAXO));

    // Error on beat 5 only, then a clean transaction
    tag = 8'h04; lat = 1; err_idx = 5; n0 = ncmd;
    issue(1'b1, 24'h000020, 256'h0, 32'h0);
    wait_done(200);
    check("err_beats", 256'(ncmd - n0), 256'(BEATS));
    tag = 8'h06; err_idx = -1;
    issue(1'b1, 24'h000060, 256'h0, 32'h0);
    wait_done(200);

    // Unaligned read address: wrap order only when the option is built in
    tag = 8'h05;
    issue(1'b1, 24'h000054, 256'h0, 32'h0);
    wait_done(200);

    // Reset after beat 3 has been issued
    tag = 8'h09; lat = 2; n0 = ncmd;
    issue(1'b1, 24'h000000, 256'h0, 32'h0);
    n = 0;
    while (ncmd < n0 + 4 && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check("beat3_issued", 256'(ncmd >= n0 + 4), 256'(1));
    rst_n = 1'b0;
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_line = '0;
    check_idle("midreset");
    @(posedge clk); #1;

    // Response held in RESP while the cache stalls for 5 cycles
    tag = 8'h0E; lat = 1;
    mem_rsp_ready = 1'b0;
    issue(1'b1, 24'h0000E0, 256'h0, 32'h0);
    n = 0;
    while (!mem_rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("resp_reached", 256'(mem_rsp_valid), 256'(1));
    repeat (5) @(posedge clk);
    #1;
    check("resp_still_valid", 256'(mem_rsp_valid), 256'(1));
    check("resp_busy", 256'(busy), 256'(1));
    mem_rsp_ready = 1'b1;
    wait_done(100);
    check("after_resp_ready", 256'(mem_cmd_ready), 256'(1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
